// File: rtl/clock_switch_ctrl.sv
// clock_switch_ctrl: sequences the glitch-free CPU clock mux between clk0
// (stock 8 MHz) and clk1 (fast clock). It stalls new bus cycles while the
// mux changes over, waits for the mux to confirm the handoff, and releases
// the bus once a settle period has passed.
//
// Build option: define CLKSW_TIMEOUT_EN to add a HANDOFF watchdog. When it
// fires, the sticky err flag is set and the controller falls back to clk0.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   STEADY  | running on the confirmed clock; dwell timer counting down
//   DRAIN   | hold_n low; waiting for the bus to go idle, or for an abort
//   HANDOFF | select has toggled; waiting for the mux ack handshake
//   SETTLE  | handoff confirmed; settle timer counting down before release
module clock_switch_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 8,
    parameter int MIN_DWELL      = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic clrn,
    input  logic req_fast,
    input  logic bus_idle,
    input  logic ack0_n,
    input  logic ack1_n,
    output logic select,
    output logic hold_n,
    output logic busy,
    output logic is_fast,
    output logic err
);

    typedef enum logic [1:0] {ST_STEADY, ST_DRAIN, ST_HANDOFF, ST_SETTLE} state_t;

    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LOAD  = DW'(MIN_DWELL);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);

    if (SYNC_STAGES < 2 || SETTLE_CYCLES < 1 || MIN_DWELL < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("clock_switch_ctrl: parameter out of range");
    end

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] ack0_sync, ack1_sync;
    logic                   ack0_s, ack1_s;
    logic                   handoff_ok;
    logic                   target;
    logic                   timeout_hit;
    logic [DW-1:0]          dwell_cnt;
    logic [SW-1:0]          settle_cnt;

    // Acks are asynchronous to clk; reset to "deasserted" so nothing looks confirmed.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ack0_sync <= '1;
            ack1_sync <= '1;
        end else begin
            ack0_sync <= {ack0_sync[SYNC_STAGES-2:0], ack0_n};
            ack1_sync <= {ack1_sync[SYNC_STAGES-2:0], ack1_n};
        end
    end

    assign ack0_s = ack0_sync[SYNC_STAGES-1];
    assign ack1_s = ack1_sync[SYNC_STAGES-1];

    // The handoff is complete only when the new path is on and the old path is off.
    // Both acks low at once is a mux fault and is not accepted as completion.
    assign handoff_ok = select ? (!ack1_s && ack0_s) : (!ack0_s && ack1_s);

`ifdef CLKSW_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wdog_cnt;
    logic          err_q;

    // Watchdog counts cycles spent in HANDOFF and clears on any other state.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wdog_cnt <= '0;
        end else if (state == ST_HANDOFF) begin
            wdog_cnt <= wdog_cnt + TW'(1);
        end else begin
            wdog_cnt <= '0;
        end
    end

    assign timeout_hit = (state == ST_HANDOFF) && !handoff_ok && (wdog_cnt == TIMEOUT_LAST);

    // err is sticky until reset; while set, the controller stays on clk0.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    assign target = req_fast & ~err;

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_STEADY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STEADY: begin
                if ((target != select) && (dwell_cnt == '0)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (target == select) state_nxt = ST_STEADY;
                else if (bus_idle)    state_nxt = ST_HANDOFF;
            end
            ST_HANDOFF: begin
                if (handoff_ok || timeout_hit) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == SW'(1)) state_nxt = ST_STEADY;
            end
            default: state_nxt = ST_STEADY;
        endcase
    end

    // Dwell and settle down-counters. An aborted drain does not reload the dwell.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dwell_cnt  <= DWELL_LOAD;
            settle_cnt <= '0;
        end else begin
            if ((state == ST_SETTLE) && (state_nxt == ST_STEADY)) begin
                dwell_cnt <= DWELL_LOAD;
            end else if ((state == ST_STEADY) && (dwell_cnt != '0)) begin
                dwell_cnt <= dwell_cnt - DW'(1);
            end

            if ((state == ST_HANDOFF) && (state_nxt == ST_SETTLE)) begin
                settle_cnt <= SETTLE_LOAD;
            end else if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt - SW'(1);
            end
        end
    end

    // Registered mux select, bus hold and confirmed-speed outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            select  <= 1'b0;
            hold_n  <= 1'b1;
            is_fast <= 1'b0;
        end else begin
            hold_n <= (state_nxt == ST_STEADY);
            if (timeout_hit) begin
                select <= 1'b0;
            end else if ((state == ST_DRAIN) && (state_nxt == ST_HANDOFF)) begin
                select <= ~select;
            end
            if ((state == ST_SETTLE) && (state_nxt == ST_STEADY)) begin
                is_fast <= select;
            end
        end
    end

    // busy flags any switch activity.
    always_comb begin
        busy = (state != ST_STEADY);
    end

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Bench for clock_switch_ctrl. Stimulus pushes the expected output vector
// {select, hold_n, busy, is_fast, err} and the cycle at which it must appear.
// A monitor pops one entry each time the output vector changes.
module tb_clock_switch_ctrl;

    logic clk = 1'b0;
    logic clrn = 1'b1;
    logic req_fast = 1'b0;
    logic bus_idle = 1'b1;
    logic ack0_n, ack1_n;
    logic select, hold_n, busy, is_fast, err;

    logic       kill_ack1 = 1'b0;
    logic       force_ack1_low = 1'b0;
    logic [2:0] sel_d = '0;
    int         cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mux model: the selected path is acknowledged three clk cycles after select.
    always @(posedge clk) sel_d <= {sel_d[1:0], select};
    assign ack0_n = sel_d[2];
    assign ack1_n = kill_ack1 ? 1'b1 : (force_ack1_low ? 1'b0 : ~sel_d[2]);

    clock_switch_ctrl dut (
        .clk      (clk),
        .clrn     (clrn),
        .req_fast (req_fast),
        .bus_idle (bus_idle),
        .ack0_n   (ack0_n),
        .ack1_n   (ack1_n),
        .select   (select),
        .hold_n   (hold_n),
        .busy     (busy),
        .is_fast  (is_fast),
        .err      (err)
    );

    typedef struct {
        int         cyc;
        logic [4:0] vec;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    int         chk_seq = 0;
    int         chk_done = 0;
    logic [4:0] chk_exp;
    string      chk_name;
    bit         done = 0;

    int         n_cmp = 0;
    int         n_bad = 0;
    bit         armed = 0;
    logic [4:0] mon_prev;
    logic [4:0] mon_vec;
    exp_t       mon_e;

    task automatic push(input int c, input logic [4:0] v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.vec  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input logic [4:0] v, input string nm);
        chk_exp  = v;
        chk_name = nm;
        chk_seq++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: checks on every output change and on explicit snapshot requests.
    always @(negedge clk) begin
        mon_vec = {select, hold_n, busy, is_fast, err};
        if (chk_seq != chk_done) begin
            n_cmp++;
            if (mon_vec !== chk_exp) begin
                n_bad++;
                $display("FAIL %s: outputs %b, want %b (cycle %0d)", chk_name, mon_vec, chk_exp, cyc);
            end
            chk_done = chk_seq;
        end
        if (!armed) begin
            mon_prev = mon_vec;
            armed    = 1;
        end else if (mon_vec !== mon_prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change: outputs %b at cycle %0d, want %b held", mon_vec, cyc, mon_prev);
            end else begin
                mon_e = exp_q.pop_front();
                if ((mon_vec !== mon_e.vec) || (cyc != mon_e.cyc)) begin
                    n_bad++;
                    $display("FAIL %s: outputs %b at cycle %0d, want %b at cycle %0d",
                             mon_e.name, mon_vec, cyc, mon_e.vec, mon_e.cyc);
                end
            end
            mon_prev = mon_vec;
        end
        if (done) begin
            while (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s: never seen, want %b at cycle %0d", mon_e.name, mon_e.vec, mon_e.cyc);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        int r;
        #1 clrn = 1'b0;
        step(3);
        check_now(5'b01000, "reset_values");
        clrn = 1'b1;

        // Idle on slow clock: no output activity.
        step(200);
        check_now(5'b01000, "idle_200");

        // Slow->fast with bus busy for 20 cycles.
        r = cyc;
        req_fast = 1'b1;
        bus_idle = 1'b0;
        push(r + 1, 5'b00100, "drain_on_busy_bus");
        step(20);
        bus_idle = 1'b1;
        push(r + 21, 5'b10100, "select_after_idle");
        push(r + 35, 5'b11010, "fast_settled");
        step(15);

        // Fast->slow request inside dwell is deferred until dwell expires.
        r = cyc;
        step(10);
        req_fast = 1'b0;
        push(r + 65, 5'b10110, "deferred_drain");
        push(r + 66, 5'b00110, "select_slow");
        push(r + 80, 5'b01000, "slow_settled");
        step(70);

        // Request pulse during DRAIN aborts; re-request needs no new dwell.
        step(70);
        r = cyc;
        bus_idle = 1'b0;
        req_fast = 1'b1;
        push(r + 1, 5'b00100, "abort_drain");
        step(3);
        req_fast = 1'b0;
        push(r + 4, 5'b01000, "abort_release");
        step(1);
        req_fast = 1'b1;
        bus_idle = 1'b1;
        push(r + 5, 5'b00100, "redrain_no_dwell");
        push(r + 6, 5'b10100, "reselect_fast");
        push(r + 20, 5'b11010, "refast_settled");
        step(16);

        // Both acks low holds HANDOFF until the stale clk1 ack drops.
        step(70);
        r = cyc;
        force_ack1_low = 1'b1;
        req_fast = 1'b0;
        push(r + 1, 5'b10110, "bothlow_drain");
        push(r + 2, 5'b00110, "bothlow_select");
        step(22);
        force_ack1_low = 1'b0;
        push(r + 33, 5'b01000, "bothlow_settled");
        step(11);

        // Reset during SETTLE: async return, then resume after a full dwell.
        step(70);
        r = cyc;
        req_fast = 1'b1;
        push(r + 1, 5'b00100, "pre_rst_drain");
        push(r + 2, 5'b10100, "pre_rst_select");
        step(10);
        clrn = 1'b0;
        push(r + 10, 5'b01000, "async_reset_change");
        check_now(5'b01000, "async_reset_values");
        step(2);
        clrn = 1'b1;
        push(r + 77, 5'b00100, "post_rst_drain");
        push(r + 78, 5'b10100, "post_rst_select");
        push(r + 92, 5'b11010, "post_rst_fast");
        step(80);
        step(5);

`ifdef CLKSW_TIMEOUT_EN
        // Mux never acknowledges clk1: watchdog forces clk0 and sets err.
        r = cyc;
        kill_ack1 = 1'b1;
        clrn = 1'b0;
        push(r, 5'b01000, "t5_reset");
        step(2);
        clrn = 1'b1;
        r = cyc;
        push(r + 65, 5'b00100, "t5_drain");
        push(r + 66, 5'b10100, "t5_select");
        push(r + 321, 5'b00101, "t5_timeout");
        push(r + 329, 5'b01001, "t5_err_settled");
        step(330);
        step(150);
        check_now(5'b01001, "t5_err_sticky");
        step(1);
        req_fast = 1'b0;
        kill_ack1 = 1'b0;
        r = cyc;
        clrn = 1'b0;
        push(r, 5'b01000, "t5_err_cleared");
        step(2);
        clrn = 1'b1;
        step(5);
`endif

        done = 1;
        step(3);
        $display("FAIL monitor_finish: summary not reached, want finish at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
